// File: rtl/ahblite_dma_master_if.sv
// rtl/ahblite_dma_master_if.sv - AHB-Lite master-side bus bundle for the DMA copy engine.
interface ahblite_dma_master_if;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahblite_dma_master.sv
// rtl/ahblite_dma_master.sv - AHB-Lite DMA engine copying words with single NONSEQ transfers.
// Optional fixed-source (FIFO drain) mode is compiled in by defining DMA_SRC_FIXED_EN.
module ahblite_dma_master #(
   parameter int         LEN_W     = 16,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] length,
`ifdef DMA_SRC_FIXED_EN
   input  logic             src_fixed,
`endif
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             irq,
   input  logic             irq_clr,
   ahblite_dma_master_if.master bus
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      data_q, data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             irq_q, irq_d;
   logic [31:0]      src_step;
   logic [1:0]       htrans;
   logic [31:0]      haddr;
   logic             hwrite;

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef DMA_SRC_FIXED_EN
   logic fixed_q, fixed_d;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         fixed_q <= 1'b0;
      end else begin
         fixed_q <= fixed_d;
      end
   end

   assign fixed_d  = (state_q == ST_IDLE && start && length != '0) ? src_fixed : fixed_q;
   assign src_step = fixed_q ? 32'd0 : 32'd4;
`else
   assign src_step = 32'd4;
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      htrans  = HTRANS_IDLE;
      haddr   = 32'd0;
      hwrite  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  src_d   = {src_addr[31:2], 2'b00};
                  dst_d   = {dst_addr[31:2], 2'b00};
                  cnt_d   = length;
                  state_d = ST_RD_A;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RD_A: begin
            htrans = HTRANS_NONSEQ;
            haddr  = src_q;
            if (bus.HREADY) begin
               state_d = ST_RD_D;
            end
         end
         ST_RD_D: begin
            // An error response is only acted on in its second (HREADY=1) cycle.
            if (bus.HREADY) begin
               if (bus.HRESP) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  data_d  = bus.HRDATA;
                  state_d = ST_WR_A;
               end
            end
         end
         ST_WR_A: begin
            htrans = HTRANS_NONSEQ;
            haddr  = dst_q;
            hwrite = 1'b1;
            if (bus.HREADY) begin
               state_d = ST_WR_D;
            end
         end
         ST_WR_D: begin
            if (bus.HREADY) begin
               if (bus.HRESP) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  src_d = src_q + src_step;
                  dst_d = dst_q + 32'd4;
                  cnt_d = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RD_A;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Completion sets irq even when software clears it in the same cycle.
      if (done_d || err_d) begin
         irq_d = 1'b1;
      end else if (irq_clr) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign err  = err_q;
   assign irq  = irq_q;

   assign bus.HTRANS    = htrans;
   assign bus.HADDR     = haddr;
   assign bus.HWRITE    = hwrite;
   assign bus.HWDATA    = data_q;
   assign bus.HSIZE     = 3'b010;
   assign bus.HBURST    = 3'b000;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HMASTLOCK = 1'b0;

endmodule
